// File: rtl/csr_counter_unit_pkg.sv
// CSR address map, counter selector and shadow-decode helper for csr_counter_unit.
package csr_pkg;

    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

    typedef enum logic {
        MCYCLE,
        MINSTRET
    } csr_counter_sel_t;

    function automatic logic is_ro_shadow(input logic [11:0] addr);
        return (addr == CSR_CYCLE)   || (addr == CSR_CYCLEH) ||
               (addr == CSR_INSTRET) || (addr == CSR_INSTRETH);
    endfunction

endpackage

// File: rtl/csr_counter_unit_if.sv
// CSR read/write port between the writeback stage (master) and the counter unit (slave).
interface csr_counter_unit_if;

    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_hit;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        illegal_write;

    modport master (
        output csr_raddr, csr_we, csr_waddr, csr_wdata,
        input  csr_rdata, csr_hit, illegal_write
    );

    modport slave (
        input  csr_raddr, csr_we, csr_waddr, csr_wdata,
        output csr_rdata, csr_hit, illegal_write
    );

endinterface

// File: rtl/csr_counter_unit_counter.sv
// One split lo/hi counter with increment enable and per-half write; a low-half
// write drops that cycle's increment, a high-half write drops the low-to-high carry.
module csr_counter #(
    parameter int unsigned COUNTER_WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     inc_i,
    input  logic                     we_lo_i,
    input  logic                     we_hi_i,
    input  logic [31:0]              wdata_i,
    output logic [COUNTER_WIDTH-1:0] count_o
);

    localparam int unsigned HW = COUNTER_WIDTH - 32;

    logic [31:0]   lo_q, lo_d;
    logic [HW-1:0] hi_q, hi_d;
    logic          carry;

    always_comb begin
        carry = inc_i & (&lo_q);
        lo_d  = lo_q;
        hi_d  = hi_q;
        if (we_lo_i) begin
            lo_d = wdata_i;
        end else begin
            lo_d = lo_q + 32'(inc_i);
        end
        if (we_hi_i) begin
            hi_d = wdata_i[HW-1:0];
        end else if (!we_lo_i) begin
            hi_d = hi_q + HW'(carry);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign count_o = {hi_q, lo_q};

endmodule

// File: rtl/csr_counter_unit.sv
// mcycle/minstret counter block with user read-only shadows.
// Optional mcountinhibit (0x320) enabled by defining CSR_MCOUNTINHIBIT_EN.
module csr_counter_unit
    import csr_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     valid_wb_i,
    input  logic                     stall_wb_i,
    csr_counter_unit_if.slave        csr
);

    logic                     retire;
    logic                     inh_cy, inh_ir;
    logic                     illegal_write_q;
    logic [COUNTER_WIDTH-1:0] mcycle, minstret;
    logic [63:0]              mcycle_x, minstret_x;
    logic                     wr_cy_lo, wr_cy_hi, wr_ir_lo, wr_ir_hi;
    csr_counter_sel_t         rsel;
    logic                     rhi, rcnt, rhit;
    logic [31:0]              rdata;

    assign retire   = valid_wb_i & ~stall_wb_i;
    assign wr_cy_lo = csr.csr_we && (csr.csr_waddr == CSR_MCYCLE);
    assign wr_cy_hi = csr.csr_we && (csr.csr_waddr == CSR_MCYCLEH);
    assign wr_ir_lo = csr.csr_we && (csr.csr_waddr == CSR_MINSTRET);
    assign wr_ir_hi = csr.csr_we && (csr.csr_waddr == CSR_MINSTRETH);

`ifdef CSR_MCOUNTINHIBIT_EN
    logic cy_inh_q, ir_inh_q;

    // Registered, so the write cycle itself still counts.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cy_inh_q <= 1'b0;
            ir_inh_q <= 1'b0;
        end else if (csr.csr_we && (csr.csr_waddr == CSR_MCOUNTINHIBIT)) begin
            cy_inh_q <= csr.csr_wdata[0];
            ir_inh_q <= csr.csr_wdata[2];
        end
    end

    assign inh_cy = cy_inh_q;
    assign inh_ir = ir_inh_q;
`else
    assign inh_cy = 1'b0;
    assign inh_ir = 1'b0;
`endif

    csr_counter #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_mcycle (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .inc_i     (~inh_cy),
        .we_lo_i   (wr_cy_lo),
        .we_hi_i   (wr_cy_hi),
        .wdata_i   (csr.csr_wdata),
        .count_o   (mcycle)
    );

    csr_counter #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_minstret (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .inc_i     (retire & ~inh_ir),
        .we_lo_i   (wr_ir_lo),
        .we_hi_i   (wr_ir_hi),
        .wdata_i   (csr.csr_wdata),
        .count_o   (minstret)
    );

    assign mcycle_x   = 64'(mcycle);
    assign minstret_x = 64'(minstret);

    always_comb begin
        rsel  = MCYCLE;
        rhi   = 1'b0;
        rcnt  = 1'b0;
        rhit  = 1'b0;
        rdata = '0;
        case (csr.csr_raddr)
            CSR_MCYCLE, CSR_CYCLE: begin
                rcnt = 1'b1;
            end
            CSR_MCYCLEH, CSR_CYCLEH: begin
                rcnt = 1'b1;
                rhi  = 1'b1;
            end
            CSR_MINSTRET, CSR_INSTRET: begin
                rcnt = 1'b1;
                rsel = MINSTRET;
            end
            CSR_MINSTRETH, CSR_INSTRETH: begin
                rcnt = 1'b1;
                rhi  = 1'b1;
                rsel = MINSTRET;
            end
            default: ;
        endcase
        if (rcnt) begin
            rhit = 1'b1;
            if (rsel == MCYCLE) begin
                rdata = rhi ? mcycle_x[63:32] : mcycle_x[31:0];
            end else begin
                rdata = rhi ? minstret_x[63:32] : minstret_x[31:0];
            end
        end
`ifdef CSR_MCOUNTINHIBIT_EN
        if (csr.csr_raddr == CSR_MCOUNTINHIBIT) begin
            rhit  = 1'b1;
            rdata = {29'b0, inh_ir, 1'b0, inh_cy};
        end
`endif
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            illegal_write_q <= 1'b0;
        end else begin
            illegal_write_q <= csr.csr_we & is_ro_shadow(csr.csr_waddr);
        end
    end

    assign csr.csr_rdata     = rdata;
    assign csr.csr_hit       = rhit;
    assign csr.illegal_write = illegal_write_q;

endmodule

// File: tb/tb_csr_counter_unit.sv
// Directed table-driven bench for csr_counter_unit, plus hand-written carry, wrap,
// inhibit and asynchronous-reset sequences.
module tb_csr_counter_unit;

    logic clk_i = 1'b0;
    logic reset_n_i;
    logic valid_wb_i;
    logic stall_wb_i;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    csr_counter_unit_if bus ();

    csr_counter_unit #(.COUNTER_WIDTH(64)) dut (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .valid_wb_i (valid_wb_i),
        .stall_wb_i (stall_wb_i),
        .csr        (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic        valid;
        logic        stall;
        logic [11:0] raddr;
        logic [31:0] exp_rdata;
        logic        exp_hit;
        logic        exp_ill;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic addv(input logic we, input logic [11:0] waddr, input logic [31:0] wdata,
                        input logic valid, input logic stall, input logic [11:0] raddr,
                        input logic [31:0] exp_rdata, input logic exp_hit, input logic exp_ill);
        vec_t v;
        v.we = we; v.waddr = waddr; v.wdata = wdata; v.valid = valid; v.stall = stall;
        v.raddr = raddr; v.exp_rdata = exp_rdata; v.exp_hit = exp_hit; v.exp_ill = exp_ill;
        tbl.push_back(v);
    endtask

    // Drive one cycle's inputs, let the rising edge happen, settle 1ns past it.
    task automatic step(input logic we, input logic [11:0] waddr, input logic [31:0] wdata,
                        input logic valid, input logic stall);
        bus.csr_we    = we;
        bus.csr_waddr = waddr;
        bus.csr_wdata = wdata;
        valid_wb_i    = valid;
        stall_wb_i    = stall;
        @(posedge clk_i);
        #1;
    endtask

    task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
        bus.csr_raddr = addr;
        #1;
        chk(name, bus.csr_rdata, exp);
    endtask

    initial begin
        reset_n_i     = 1'b0;
        valid_wb_i    = 1'b0;
        stall_wb_i    = 1'b0;
        bus.csr_we    = 1'b0;
        bus.csr_waddr = '0;
        bus.csr_wdata = '0;
        bus.csr_raddr = 12'hB00;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        rd("rst_mcycle_lo", 12'hB00, 32'd0);
        chk("rst_hit", {31'b0, bus.csr_hit}, 32'd1);
        rd("rst_minstret_lo", 12'hB02, 32'd0);
        rd("rst_mcycle_hi", 12'hB80, 32'd0);
        chk("rst_illegal", {31'b0, bus.illegal_write}, 32'd0);

        // 100 idle cycles after release
        reset_n_i = 1'b1;
        repeat (100) step(1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
        rd("idle_mcycle_lo", 12'hB00, 32'd100);
        rd("idle_cycle_shadow", 12'hC00, 32'd100);
        rd("idle_mcycle_hi", 12'hB80, 32'd0);
        rd("idle_minstret", 12'hB02, 32'd0);

        // we  waddr    wdata          v  s  raddr    exp        hit ill
        addv(0, 12'h000, 32'h0,        1, 1, 12'hB02, 32'd0,     1, 0);
        addv(0, 12'h000, 32'h0,        1, 0, 12'hB02, 32'd1,     1, 0);
        addv(0, 12'h000, 32'h0,        0, 0, 12'hB02, 32'd1,     1, 0);
        addv(0, 12'h000, 32'h0,        0, 1, 12'hB02, 32'd1,     1, 0);
        addv(0, 12'h000, 32'h0,        1, 0, 12'hB02, 32'd2,     1, 0);
        addv(0, 12'h000, 32'h0,        1, 0, 12'hB02, 32'd3,     1, 0);
        addv(0, 12'h000, 32'h0,        1, 1, 12'hB02, 32'd3,     1, 0);
        addv(0, 12'h000, 32'h0,        1, 0, 12'hB02, 32'd4,     1, 0);
        addv(1, 12'hB02, 32'h5,        1, 0, 12'hB02, 32'd5,     1, 0);
        addv(0, 12'h000, 32'h0,        1, 0, 12'hB02, 32'd6,     1, 0);
        addv(1, 12'hC02, 32'h0,        1, 0, 12'hB02, 32'd7,     1, 1);
        addv(0, 12'h000, 32'h0,        0, 0, 12'hB02, 32'd7,     1, 0);
        addv(1, 12'h123, 32'hDEAD,     0, 0, 12'h123, 32'd0,     0, 0);
        addv(1, 12'hB82, 32'h2,        1, 0, 12'hB82, 32'd2,     1, 0);
        addv(0, 12'h000, 32'h0,        0, 0, 12'hB02, 32'd8,     1, 0);
        addv(0, 12'h000, 32'h0,        0, 0, 12'hC82, 32'd2,     1, 0);
        addv(1, 12'hB80, 32'h3,        0, 0, 12'hB80, 32'd3,     1, 0);
`ifdef CSR_MCOUNTINHIBIT_EN
        addv(0, 12'h000, 32'h0,        0, 0, 12'h320, 32'd0,     1, 0);
`else
        addv(0, 12'h000, 32'h0,        0, 0, 12'h320, 32'd0,     0, 0);
`endif
        addv(1, 12'hC80, 32'h9,        0, 0, 12'hB80, 32'd3,     1, 1);

        foreach (tbl[i]) begin
            bus.csr_raddr = tbl[i].raddr;
            step(tbl[i].we, tbl[i].waddr, tbl[i].wdata, tbl[i].valid, tbl[i].stall);
            chk($sformatf("vec%0d_rdata", i), bus.csr_rdata, tbl[i].exp_rdata);
            chk($sformatf("vec%0d_hit", i), {31'b0, bus.csr_hit}, {31'b0, tbl[i].exp_hit});
            chk($sformatf("vec%0d_illegal", i), {31'b0, bus.illegal_write}, {31'b0, tbl[i].exp_ill});
        end

        // valid held, stall toggling 1/0 for 20 cycles: 10 retires on top of 8
        for (int i = 0; i < 20; i++) step(1'b0, 12'h000, 32'h0, 1'b1, (i % 2) == 0);
        rd("toggle_minstret", 12'hB02, 32'd18);
        rd("toggle_minstret_hi", 12'hB82, 32'd2);

        // mcycle low wrap carries into high
        step(1'b1, 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0);
        rd("wlo_mcycle_lo", 12'hB00, 32'hFFFF_FFFF);
        rd("wlo_mcycle_hi", 12'hB80, 32'd3);
        step(1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
        step(1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
        rd("carry_mcycle_lo", 12'hB00, 32'd1);
        rd("carry_mcycle_hi", 12'hB80, 32'd4);

        // High-half write drops the carry out of the low half that cycle
        step(1'b1, 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step(1'b1, 12'hB80, 32'h7, 1'b0, 1'b0);
        rd("dropc_mcycle_lo", 12'hB00, 32'd0);
        rd("dropc_mcycle_hi", 12'hB80, 32'd7);
        step(1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
        rd("after_dropc_lo", 12'hB00, 32'd1);

        // Low-half write drops that cycle's increment
        step(1'b1, 12'hB00, 32'd10, 1'b0, 1'b0);
        rd("wlo_noinc", 12'hB00, 32'd10);
        step(1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
        rd("wlo_next", 12'hB00, 32'd11);

        // Shadow write: one-cycle flag, mcycle unaffected
        step(1'b1, 12'hC00, 32'h0, 1'b0, 1'b0);
        rd("shadow_mcycle", 12'hB00, 32'd12);
        chk("shadow_ill_pulse", {31'b0, bus.illegal_write}, 32'd1);
        step(1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
        rd("shadow_mcycle_next", 12'hB00, 32'd13);
        chk("shadow_ill_clear", {31'b0, bus.illegal_write}, 32'd0);

        // Read in the write cycle returns the pre-write value
        bus.csr_we    = 1'b1;
        bus.csr_waddr = 12'hB00;
        bus.csr_wdata = 32'h50;
        rd("rdw_pre", 12'hB00, 32'd13);
        @(posedge clk_i);
        #1;
        chk("rdw_post", bus.csr_rdata, 32'h50);
        bus.csr_we = 1'b0;

        // minstret all-ones wraps to zero
        step(1'b1, 12'hB82, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step(1'b1, 12'hB02, 32'hFFFF_FFFF, 1'b0, 1'b0);
        rd("wrap_pre_lo", 12'hB02, 32'hFFFF_FFFF);
        step(1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
        rd("wrap_lo", 12'hB02, 32'd0);
        rd("wrap_hi", 12'hB82, 32'd0);

`ifdef CSR_MCOUNTINHIBIT_EN
        step(1'b1, 12'hB02, 32'h20, 1'b0, 1'b0);
        step(1'b1, 12'hB00, 32'h100, 1'b0, 1'b0);
        step(1'b1, 12'h320, 32'hFF, 1'b0, 1'b0);
        rd("inh_write_cycle_counts", 12'hB00, 32'h101);
        rd("inh_readback", 12'h320, 32'h5);
        repeat (50) step(1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
        rd("inh_mcycle_frozen", 12'hB00, 32'h101);
        rd("inh_minstret_frozen", 12'hB02, 32'h20);
        step(1'b1, 12'h320, 32'h0, 1'b1, 1'b0);
        rd("uninh_write_cycle_mcycle", 12'hB00, 32'h101);
        rd("uninh_write_cycle_minstret", 12'hB02, 32'h20);
        step(1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
        rd("resume_mcycle", 12'hB00, 32'h102);
        rd("resume_minstret", 12'hB02, 32'h21);
`endif

        // Asynchronous reset mid-count, away from any clock edge
        step(1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
        reset_n_i = 1'b0;
        rd("arst_mcycle", 12'hB00, 32'd0);
        rd("arst_minstret", 12'hB02, 32'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        step(1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
        rd("arst_first_inc", 12'hB00, 32'd1);
        rd("arst_minstret_after", 12'hB02, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
